// File: rtl/neuro_pkg.sv
// Shared definitions for the neuron pipeline stages: half-float width,
// the feed stage FSM encoding and a handy half-float constant.
package neuro_pkg;

    // Width of one half-precision word as consumed by the add stage.
    localparam int HALF_W = 16;

    // Half-float 1.0, used by benches to build simple frames.
    localparam logic [HALF_W-1:0] HALF_ONE = 16'h3C00;

    // Feed stage control states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } feedState_t;

endpackage

// File: rtl/feed_stage.sv
// Feed stage: streams numTerms consecutive half-float words from a
// synchronous-read memory to the add stage, one word per unpaused cycle.
//
// Stream handshake: outReady is a one-cycle qualifier for outValue. There is
// no back-pressure from the consumer; the only throttle is pause, which stops
// new memory reads but never drops a read that is already in flight. Each
// outReady pulse carries exactly one word, in address order.
//
// Timing: a read issued in cycle t (memRdEn=1) returns memData in t+1, which
// is registered so outValue/outReady appear in t+2. With pause low the first
// word appears 3 cycles after the start cycle.
module feed_stage
    import neuro_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = HALF_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [15:0]       numTerms,
    input  logic [ADDR_W-1:0] baseAddr,
    input  logic              pause,
    output logic              memRdEn,
    output logic [ADDR_W-1:0] memAddr,
    input  logic [DATA_W-1:0] memData,
    output logic              outReady,
    output logic [DATA_W-1:0] outValue,
    output logic              outFirst,
    output logic [15:0]       newNumAdds,
    output logic              busy,
    output logic              done,
    output feedState_t        dbgState
);

    localparam logic [ADDR_W-1:0] ADDR_ONE = 1;

    feedState_t        state;
    logic [ADDR_W-1:0] addrPtr;
    logic [15:0]       remaining;
    logic              issued;
    logic              firstPending;
    logic              issueNow;

    // A read goes out every ISSUE cycle that is not paused; the address is
    // the live pointer so the memory sees it in the same cycle as the strobe.
    assign issueNow = (state == ISSUE) && !pause;
    assign memRdEn  = issueNow;
    assign memAddr  = addrPtr;
    assign dbgState = state;

    // Read-valid delay line and output register: issued marks memData valid
    // this cycle, and the word is captured into outValue with outReady.
    always_ff @(posedge clk) begin
        if (rst) begin
            issued   <= 1'b0;
            outReady <= 1'b0;
            outValue <= '0;
            outFirst <= 1'b0;
        end else begin
            issued   <= issueNow;
            outReady <= issued;
            if (issued) begin
                outValue <= memData;
                outFirst <= firstPending;
            end else begin
                outFirst <= 1'b0;
            end
        end
    end

    // Frame control: start acceptance, read pointer/down-counter, drain of
    // the last in-flight word and the one-cycle done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            addrPtr      <= '0;
            remaining    <= '0;
            firstPending <= 1'b0;
            newNumAdds   <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            done <= 1'b0;
            // The first word captured clears the marker for the rest of the frame.
            if (issued) begin
                firstPending <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        newNumAdds   <= numTerms;
                        addrPtr      <= baseAddr;
                        remaining    <= numTerms;
                        firstPending <= 1'b1;
                        busy         <= 1'b1;
                        if (numTerms == 16'd0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (!pause) begin
                        addrPtr   <= addrPtr + ADDR_ONE;
                        remaining <= remaining - 16'd1;
                        if (remaining == 16'd1) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // Only the final read is in flight here; leave once it has
                    // been presented on outValue.
                    if (outReady && !issued) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_feed_stage.sv
// Directed bench for feed_stage: reset, basic frame timing, pause gaps,
// address wrap, empty frame, ignored restart, abort and an add-stage chain.
module tb_feed_stage;
    import neuro_pkg::*;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 16;

    logic              clk;
    logic              rst;
    logic              start;
    logic [15:0]       numTerms;
    logic [ADDR_W-1:0] baseAddr;
    logic              pause;
    logic              memRdEn;
    logic [ADDR_W-1:0] memAddr;
    logic [DATA_W-1:0] memData;
    logic              outReady;
    logic [DATA_W-1:0] outValue;
    logic              outFirst;
    logic [15:0]       newNumAdds;
    logic              busy;
    logic              done;
    feedState_t        dbgState;

    feed_stage #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .numTerms   (numTerms),
        .baseAddr   (baseAddr),
        .pause      (pause),
        .memRdEn    (memRdEn),
        .memAddr    (memAddr),
        .memData    (memData),
        .outReady   (outReady),
        .outValue   (outValue),
        .outFirst   (outFirst),
        .newNumAdds (newNumAdds),
        .busy       (busy),
        .done       (done),
        .dbgState   (dbgState)
    );

    // ---------------- clock / reset / memory ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [DATA_W-1:0] mem [256];
    always @(posedge clk) if (memRdEn) memData <= mem[memAddr];

    // ---------------- scoreboard / monitor ----------------
    int errors = 0;
    int checks = 0;

    logic [DATA_W-1:0] expQ[$];
    logic [DATA_W-1:0] gotVal[$];
    int                gotCyc[$];
    logic              gotFirst[$];
    logic [ADDR_W-1:0] gotAddr[$];
    int                doneCyc[$];
    int                badNum = 0;
    logic [15:0]       expNum = '0;
    int                startCyc = 0;

    real               accSum = 0.0;
    int                accCnt = 0;
    logic              accReady = 1'b0;
    logic [15:0]       accOut = '0;

    function automatic real halfToReal(input logic [15:0] h);
        real v;
        int  e;
        e = int'(h[14:10]);
        v = (e == 0) ? real'(h[9:0]) : real'(1024 + int'(h[9:0]));
        if (e == 0) e = 1;
        for (int i = 0; i < 25; i++) v = v / 2.0;
        for (int i = 0; i < e; i++) v = v * 2.0;
        return h[15] ? -v : v;
    endfunction

    function automatic logic [15:0] realToHalf(input real x);
        real v;
        int  e;
        int  m;
        logic [4:0] e5;
        logic [9:0] m10;
        v = x;
        e = 15;
        if (v <= 0.0) return 16'h0000;
        while (v >= 2.0) begin v = v / 2.0; e++; end
        while (v < 1.0)  begin v = v * 2.0; e--; end
        m   = $rtoi((v - 1.0) * 1024.0 + 0.5);
        e5  = e[4:0];
        m10 = m[9:0];
        return {1'b0, e5, m10};
    endfunction

    // Capture every observable event away from the rising edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (outReady) begin
                gotVal.push_back(outValue);
                gotCyc.push_back(cyc);
                gotFirst.push_back(outFirst);
                accSum = accSum + halfToReal(outValue);
                accCnt = accCnt + 1;
                if (accCnt == int'(newNumAdds)) begin
                    accOut   = realToHalf(accSum);
                    accReady = 1'b1;
                end
            end
            if (memRdEn) gotAddr.push_back(memAddr);
            if (done) doneCyc.push_back(cyc);
            if (busy && newNumAdds != expNum) badNum++;
        end
    end

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic clearLogs();
        expQ.delete();
        gotVal.delete();
        gotCyc.delete();
        gotFirst.delete();
        gotAddr.delete();
        doneCyc.delete();
        badNum   = 0;
        accSum   = 0.0;
        accCnt   = 0;
        accReady = 1'b0;
    endtask

    task automatic startFrame(input logic [15:0] n, input logic [ADDR_W-1:0] base);
        @(posedge clk); #1;
        start    = 1'b1;
        numTerms = n;
        baseAddr = base;
        expNum   = n;
        startCyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic waitDone(input string tag, input int budget);
        for (int k = 0; k < budget; k++) begin
            @(posedge clk);
            if (doneCyc.size() > 0) break;
        end
        checkVal(tag, doneCyc.size(), 1);
        @(posedge clk); #1;
    endtask

    task automatic checkStream(input string tag);
        checkVal({tag, "_count"}, gotVal.size(), expQ.size());
        for (int i = 0; i < expQ.size() && i < gotVal.size(); i++) begin
            checkVal($sformatf("%s_word%0d", tag, i), gotVal[i], expQ[i]);
        end
        checkVal({tag, "_numAddsHeld"}, badNum, 0);
    endtask

    // ---------------- directed tests ----------------
    initial begin
        rst      = 1'b1;
        start    = 1'b1;
        numTerms = 16'd3;
        baseAddr = '0;
        pause    = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 16'(16'h1000 + i);

        // Reset held two cycles with start asserted: everything stays quiet.
        for (int r = 0; r < 2; r++) begin
            @(posedge clk); #1;
            @(negedge clk);
            checkVal("rst_memRdEn", memRdEn, 0);
            checkVal("rst_memAddr", memAddr, 0);
            checkVal("rst_outReady", outReady, 0);
            checkVal("rst_outValue", outValue, 0);
            checkVal("rst_outFirst", outFirst, 0);
            checkVal("rst_newNumAdds", newNumAdds, 0);
            checkVal("rst_busy", busy, 0);
            checkVal("rst_done", done, 0);
        end
        @(posedge clk); #1;
        rst   = 1'b0;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Basic frame: words on cycles +3..+5, done on +6.
        clearLogs();
        mem[0] = 16'h3C00; mem[1] = 16'h4000; mem[2] = 16'h4200;
        expQ = '{16'h3C00, 16'h4000, 16'h4200};
        startFrame(16'd3, 8'h00);
        @(negedge clk);
        checkVal("basic_busy", busy, 1);
        waitDone("basic_done", 20);
        checkStream("basic");
        if (gotCyc.size() == 3) begin
            checkVal("basic_cyc0", gotCyc[0] - startCyc, 3);
            checkVal("basic_cyc1", gotCyc[1] - startCyc, 4);
            checkVal("basic_cyc2", gotCyc[2] - startCyc, 5);
            checkVal("basic_first0", gotFirst[0], 1);
            checkVal("basic_first1", gotFirst[1], 0);
            checkVal("basic_first2", gotFirst[2], 0);
        end
        checkVal("basic_doneCyc", doneCyc[0] - startCyc, 6);
        @(negedge clk);
        checkVal("basic_idleBusy", busy, 0);
        checkVal("basic_retained", newNumAdds, 3);
        checkVal("basic_holdValue", outValue, 16'h4200);

        // Pause for two cycles after the first read.
        clearLogs();
        mem[16] = 16'hA001; mem[17] = 16'hA002; mem[18] = 16'hA003; mem[19] = 16'hA004;
        expQ = '{16'hA001, 16'hA002, 16'hA003, 16'hA004};
        startFrame(16'd4, 8'd16);
        @(posedge clk); #1; pause = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1; pause = 1'b0;
        waitDone("pause_done", 20);
        checkStream("pause");
        if (gotCyc.size() == 4) begin
            checkVal("pause_cyc0", gotCyc[0] - startCyc, 3);
            checkVal("pause_cyc1", gotCyc[1] - startCyc, 6);
            checkVal("pause_cyc3", gotCyc[3] - startCyc, 8);
        end
        checkVal("pause_doneCyc", doneCyc[0] - startCyc, 9);

        // Address wrap past the top of the memory.
        clearLogs();
        mem[8'hFE] = 16'hB0FE; mem[8'hFF] = 16'hB0FF; mem[0] = 16'hB000; mem[1] = 16'hB001;
        expQ = '{16'hB0FE, 16'hB0FF, 16'hB000, 16'hB001};
        startFrame(16'd4, 8'hFE);
        waitDone("wrap_done", 20);
        checkStream("wrap");
        checkVal("wrap_reads", gotAddr.size(), 4);
        if (gotAddr.size() == 4) begin
            checkVal("wrap_addr0", gotAddr[0], 8'hFE);
            checkVal("wrap_addr1", gotAddr[1], 8'hFF);
            checkVal("wrap_addr2", gotAddr[2], 8'h00);
            checkVal("wrap_addr3", gotAddr[3], 8'h01);
        end

        // Empty frame: a done pulse and nothing else.
        clearLogs();
        startFrame(16'd0, 8'd5);
        waitDone("zero_done", 10);
        checkVal("zero_doneLat", (doneCyc[0] - startCyc) <= 2, 1);
        checkVal("zero_reads", gotAddr.size(), 0);
        checkVal("zero_words", gotVal.size(), 0);
        checkVal("zero_numAdds", newNumAdds, 0);
        repeat (3) @(posedge clk);
        checkVal("zero_singleDone", doneCyc.size(), 1);

        // Second start while busy is ignored.
        clearLogs();
        for (int i = 0; i < 5; i++) begin
            mem[32 + i] = 16'(16'hC000 + i);
            expQ.push_back(16'(16'hC000 + i));
        end
        startFrame(16'd5, 8'd32);
        @(posedge clk); #1;
        start = 1'b1; numTerms = 16'd9; baseAddr = 8'd100;
        @(posedge clk); #1;
        start = 1'b0;
        waitDone("ignore_done", 30);
        checkStream("ignore");
        checkVal("ignore_reads", gotAddr.size(), 5);
        if (gotAddr.size() == 5) checkVal("ignore_lastAddr", gotAddr[4], 8'd36);
        checkVal("ignore_numAdds", newNumAdds, 5);

        // Abort with reset after two words.
        clearLogs();
        for (int i = 0; i < 5; i++) mem[40 + i] = 16'(16'hD000 + i);
        startFrame(16'd5, 8'd40);
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            if (gotVal.size() >= 2) break;
        end
        checkVal("abort_twoWords", gotVal.size(), 2);
        #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        clearLogs();
        expNum = '0;
        @(negedge clk);
        checkVal("abort_outReady", outReady, 0);
        checkVal("abort_busy", busy, 0);
        checkVal("abort_memRdEn", memRdEn, 0);
        checkVal("abort_numAdds", newNumAdds, 0);
        checkVal("abort_outValue", outValue, 0);
        repeat (8) @(posedge clk);
        checkVal("abort_noWords", gotVal.size(), 0);
        checkVal("abort_noDone", doneCyc.size(), 0);
        #1;

        // Chain into an add-stage model: 1.0 + 1.0 + 1.0 = 3.0.
        clearLogs();
        for (int i = 0; i < 3; i++) begin
            mem[60 + i] = HALF_ONE;
            expQ.push_back(HALF_ONE);
        end
        startFrame(16'd3, 8'd60);
        waitDone("chain_done", 20);
        checkStream("chain");
        checkVal("chain_accReady", accReady, 1);
        checkVal("chain_accResult", accOut, 16'h4200);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Absolute time guard so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "time limit");
    end

endmodule
